// File: rtl/wf_bram.sv
// Simple-dual-port byte-strobed RAM with write-first forwarding and a clear sweep.
// Optional WF_BRAM_OUTREG_EN adds an output register stage (read latency 2).
module wf_bram #(
  parameter int DEPTH = 512,
  parameter int DATA_WIDTH = 64,
  parameter int BYTE_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wen,
  input  logic [$clog2(DEPTH)-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      ren,
  input  logic [$clog2(DEPTH)-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]     rdata,
  input  logic                      clr_req,
  output logic                      ready
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t state, state_nx;
  logic [AW-1:0] clr_ptr, ptr_nx;

  logic [NB-1:0]         mem_we;
  logic [AW-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_en;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_q;

  logic [NB-1:0]         fwd_mask;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  hit;
  logic [DATA_WIDTH-1:0] merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= ptr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = clr_ptr;
    mem_we    = '0;
    mem_addr  = waddr;
    mem_wdata = wdata;
    rd_en     = 1'b0;
    ready     = 1'b0;
    unique case (state)
      CLEAR: begin
        mem_we    = '1;
        mem_addr  = clr_ptr;
        mem_wdata = INIT_VALUE;
        ptr_nx    = clr_ptr + 1'b1;
        if (clr_ptr == AW'(DEPTH - 1))
          state_nx = IDLE;
      end
      IDLE: begin
        ready  = 1'b1;
        mem_we = wen;
        rd_en  = ren;
        if (clr_req) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  // Read-first array; no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (rd_en)
      mem_q <= mem[raddr];
    for (int i = 0; i < NB; i++)
      if (mem_we[i])
        mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
          mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
  end

  // hit masks the unreset array output until the first real read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_mask <= '0;
      fwd_data <= '0;
      hit      <= 1'b0;
    end else if (rd_en) begin
      fwd_mask <= (raddr == waddr) ? wen : '0;
      fwd_data <= wdata;
      hit      <= 1'b1;
    end
  end

  always_comb begin
    merged = '0;
    if (hit)
      for (int i = 0; i < NB; i++)
        merged[i*BYTE_WIDTH +: BYTE_WIDTH] = fwd_mask[i] ?
          fwd_data[i*BYTE_WIDTH +: BYTE_WIDTH] :
          mem_q[i*BYTE_WIDTH +: BYTE_WIDTH];
  end

`ifdef WF_BRAM_OUTREG_EN
  logic                  ren_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ren_d   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ren_d <= rd_en;
      if (ren_d)
        rdata_q <= merged;
    end
  end

  assign rdata = rdata_q;
`else
  assign rdata = merged;
`endif

endmodule

// File: tb/tb_wf_bram.sv
// Directed bench for wf_bram: DEPTH=16, INIT_VALUE=64'hA5.
// Follows WF_BRAM_OUTREG_EN to pick read latency.
module tb_wf_bram;

  localparam int DEPTH = 16;
  localparam int DW = 64;
  localparam int NB = 8;
  localparam int AW = 4;
  localparam logic [DW-1:0] INIT = 64'hA5;
`ifdef WF_BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          ren;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          clr_req;
  logic          ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wf_bram #(
    .DEPTH(DEPTH),
    .DATA_WIDTH(DW),
    .BYTE_WIDTH(8),
    .INIT_VALUE(INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wen(wen),
    .waddr(waddr),
    .wdata(wdata),
    .ren(ren),
    .raddr(raddr),
    .rdata(rdata),
    .clr_req(clr_req),
    .ready(ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a read, wait out the latency, leave rdata for the caller
  task automatic rd(input logic [AW-1:0] a);
    ren   = 1'b1;
    raddr = a;
    tick();
    ren = 1'b0;
    repeat (LAT - 1) tick();
  endtask

  task automatic sweep_and_check(input string tag);
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      if (k == DEPTH - 1) begin
        n_vec++;
        if (ready !== 1'b0) begin
          n_err++;
          $display("FAIL %s ready_early got=%b want=0", tag, ready);
        end
      end
    end
    n_vec++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_late got=%b want=1", tag, ready);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd(AW'(a));
      n_vec++;
      if (rdata !== INIT) begin
        n_err++;
        $display("FAIL %s init_rd a=%0d got=%h want=%h", tag, a, rdata, INIT);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wen = '0; waddr = '0; wdata = '0;
    ren = 1'b0; raddr = '0; clr_req = 1'b0;
    tick();
    tick();
    n_vec++;
    if (ready !== 1'b0 || rdata !== '0) begin
      n_err++;
      $display("FAIL reset got ready=%b rdata=%h want 0/0", ready, rdata);
    end
    rst = 1'b0;
    sweep_and_check("reset_sweep");
  endtask

  task automatic test_write_read();
    wen = 8'hFF; waddr = 4'd3; wdata = 64'h1122334455667788;
    tick();
    wen = '0;
    rd(4'd3);
    n_vec++;
    if (rdata !== 64'h1122334455667788) begin
      n_err++;
      $display("FAIL wr_rd got=%h want=1122334455667788", rdata);
    end
  endtask

  task automatic test_collision();
    wen = 8'h0F; waddr = 4'd3; wdata = 64'hFFFFFFFF_DEADBEEF;
    ren = 1'b1; raddr = 4'd3;
    tick();
    wen = '0; ren = 1'b0;
`ifdef WF_BRAM_OUTREG_EN
    n_vec++;
    if (rdata !== 64'h1122334455667788) begin
      n_err++;
      $display("FAIL coll_early got=%h want=1122334455667788", rdata);
    end
    tick();
`endif
    n_vec++;
    if (rdata !== 64'h11223344DEADBEEF) begin
      n_err++;
      $display("FAIL coll got=%h want=11223344deadbeef", rdata);
    end
    repeat (2) tick();
    n_vec++;
    if (rdata !== 64'h11223344DEADBEEF) begin
      n_err++;
      $display("FAIL coll_hold got=%h want=11223344deadbeef", rdata);
    end
  endtask

  task automatic test_hold();
    rd(4'd5);
    n_vec++;
    if (rdata !== INIT) begin
      n_err++;
      $display("FAIL hold_rd got=%h want=%h", rdata, INIT);
    end
    for (int c = 0; c < 3; c++) begin
      wen = 8'hFF; waddr = 4'd5; wdata = 64'hCAFE0000_0000BEE0 + 64'(c);
      tick();
      n_vec++;
      if (rdata !== INIT) begin
        n_err++;
        $display("FAIL hold c=%0d got=%h want=%h", c, rdata, INIT);
      end
    end
    wen = '0;
    rd(4'd5);
    n_vec++;
    if (rdata !== 64'hCAFE0000_0000BEE2) begin
      n_err++;
      $display("FAIL hold_new got=%h want=cafe00000000bee2", rdata);
    end
  endtask

  task automatic test_clear_req();
    clr_req = 1'b1;
    wen = 8'hFF; waddr = 4'd7; wdata = 64'h7777_7777_7777_7777;
    tick();
    clr_req = 1'b0; wen = '0;
    n_vec++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL clr_drop got=%b want=0", ready);
    end
    sweep_and_check("clr_sweep");
  endtask

  task automatic test_rst_mid_sweep();
    wen = 8'hFF; waddr = 4'd9; wdata = 64'h9999;
    tick();
    wen = '0;
    rd(4'd9);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    n_vec++;
    if (ready !== 1'b0 || rdata !== '0) begin
      n_err++;
      $display("FAIL rst_mid got ready=%b rdata=%h want 0/0", ready, rdata);
    end
    tick();
    rst = 1'b0;
    sweep_and_check("rst_sweep");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_hold();
    test_clear_req();
    test_rst_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wf_bram.md
# wf_bram

Parametrised simple-dual-port block RAM with per-byte write strobes, byte-merged write-first forwarding, and a hardware clear engine. It is the general storage primitive for cache tag/data arrays and predictor tables: one write port, one read port, one clock. After reset, or on request, it sweeps every entry to a known value so that callers never read uninitialised lines.

## Interface
- `DEPTH`, 512: number of entries; power of two, at least 2.
- `DATA_WIDTH`, 64: bits per entry; a multiple of `BYTE_WIDTH`.
- `BYTE_WIDTH`, 8: bits per write strobe. `NB = DATA_WIDTH/BYTE_WIDTH`; `AW = $clog2(DEPTH)`.
- `INIT_VALUE`, 0: `DATA_WIDTH`-bit value written to every entry by the clear engine.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `wen`  in  NB  per-byte write strobe; a write occurs when any bit is set.
- `waddr`  in  AW  write address.
- `wdata`  in  DATA_WIDTH  write data.
- `ren`  in  1  read enable.
- `raddr`  in  AW  read address.
- `rdata`  out  DATA_WIDTH  read data.
- `clr_req`  in  1  single-cycle pulse that starts a full clear sweep.
- `ready`  out  1  high when user ports are accepted; low while clearing.

## Operation
- The clear engine is a two-state FSM, `CLEAR` and `IDLE`, with an `AW`-bit counter `clr_ptr`.
- Reset forces `CLEAR` with `clr_ptr=0`.
  - Every `CLEAR` cycle writes `INIT_VALUE` to `clr_ptr` with all strobes set, then increments the counter.
  - At `clr_ptr==DEPTH-1` the FSM goes to `IDLE` and the counter wraps to 0.
- `IDLE` plus `clr_req` moves to `CLEAR` with `clr_ptr=0`. `clr_req` is ignored while in `CLEAR`.
- While in `CLEAR`:
  - User `wen` and `ren` are ignored.
  - `rdata` holds its value.
  - `ready=0`.
- User write, accepted only in `IDLE`: for each `i` with `wen[i]=1`, byte `i` of the entry at `waddr` takes byte `i` of `wdata`. Other bytes are unchanged.
- User read, accepted only in `IDLE` with `ren=1`: `rdata` returns the entry at `raddr` as it stands after any write in the same cycle.
  - This is write-first, byte-merged.
  - On collision (`raddr==waddr` and `|wen`), byte `i` of the result is `wdata` byte `i` if `wen[i]`, otherwise the stored byte.
  - The merge uses a registered strobe mask, registered `wdata` and the array output.
  - The array itself is inferred RAM with read-first behaviour; forwarding is fabric logic.
- `ren=0` holds `rdata` at its previous value, including any forwarded bytes.
- The array is never reset; only the sweep initialises it.

## Timing
- Reset values: `rdata=0`, `ready=0`, state `CLEAR`, `clr_ptr=0`, forwarding registers 0.
- Clear duration:
  - Sweep cycles are the `DEPTH` cycles starting with the first `clk` edge after `rst` falls.
  - `ready` rises after the `DEPTH`th edge.
  - A read issued in the first `ready` cycle returns `INIT_VALUE` at any address.
- A `clr_req` sampled in `IDLE` drops `ready` on the next edge. `ready` returns `DEPTH` edges later. A user write in that same request cycle is still performed, and the sweep then overwrites it.
- Read latency is 1 cycle: `raddr` and `ren` are sampled at edge N, and `rdata` is valid after edge N.
- Write latency is 1: a read at edge N+1 sees a write made at edge N, served from the array without forwarding.
- `rst` asserted mid-sweep or mid-read immediately restores all reset values; the sweep restarts from address 0.

## Configuration
- `WF_BRAM_OUTREG_EN` defined:
  - An extra output register stage is added, and read latency becomes 2.
  - The stage is enabled by `ren` delayed one cycle.
  - Data reflects the array at read-issue time plus same-cycle merge. A write in the cycle after the read is not forwarded.
  - The register resets to 0.
  - `ready` timing is unchanged.
- `WF_BRAM_OUTREG_EN` undefined: latency 1 as described above.

## Test plan
- Reset release with `DEPTH=16`, `INIT_VALUE=64'hA5`: `ready` rises after edge 16; reads of addresses 0..15 all return `64'hA5`.
- Write `wen=8'hFF` of `64'h1122334455667788` to addr 3, then read addr 3 next cycle: `rdata=64'h1122334455667788`.
- Same cycle: write `wen=8'h0F`, `wdata=64'hFFFFFFFF_DEADBEEF` to addr 3 and read addr 3: `rdata=64'h11223344DEADBEEF`.
- Read addr 5, then `ren=0` for 3 cycles while writing addr 5: `rdata` is held at the old value; the next read returns the new data.
- `clr_req` pulse, then `rst` asserted at sweep cycle 7: `ready=0` and `rdata=0` immediately; after release the full 16-cycle sweep completes and all entries read `INIT_VALUE`.
- With `WF_BRAM_OUTREG_EN` defined, repeat the collision scenario: `64'h11223344DEADBEEF` appears exactly 2 cycles after issue.
